serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer around a single one-bit dataflow full adder.
- Accepts two WIDTH-bit operands on a start pulse, feeds them LSB-first through the adder, one bit per clock, and carries the running carry in a flip-flop.
- Returns the WIDTH-bit result, carry-out and signed overflow with a one-cycle done pulse.
- Sits between a host/ALU sequencer and the shared full-adder cell; trades latency for area.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = A+B+Cin, 1 = A-B (Cin ignored); sampled with start.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- Cin  in  1  carry-in for add; sampled with start.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse when results become valid.
- Sum  out  WIDTH  result; held until the next accepted start.
- Cout  out  1  final carry; for subtract, 1 = no borrow.
- Ovf  out  1  signed overflow, two's-complement interpretation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - Shift registers, carry FF and bit counter are cleared.
  - Reset during RUN aborts the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge E, load a_sh=A and b_sh = sub ? ~B : B.
  - Load carry = sub ? 1 : Cin; cnt=0; go to RUN.
  - Sum/Cout/Ovf keep their previous values until the new result is written in the DONE transition.
- RUN, each edge:
  - Apply FA inputs (a_sh[0], b_sh[0], carry).
  - Shift the FA sum bit into the MSB of sum_sh, shifting sum_sh right.
  - Shift a_sh and b_sh right by one.
  - carry <= FA carry; cnt++.
  - On the edge where cnt==WIDTH-1 (last bit), latch c_msb_in = carry (carry into the MSB), then go to DONE.
  - On that same edge, write Sum (full shifted result), Cout = FA carry, Ovf = c_msb_in ^ FA carry.
- DONE: done=1 for exactly one cycle, then unconditional transition to IDLE. start is ignored while in DONE.
- busy = (state==RUN).
- Latency: start sampled at edge E -> busy high from E to E+WIDTH -> done high in the cycle after edge E+WIDTH. Next start is accepted at edge E+WIDTH+2 at the earliest.
- start while in RUN or DONE: ignored, with no effect on the in-flight operation and no queuing.
- Operand, sub or Cin changes after the start edge: no effect; everything is captured at the start edge.
- WIDTH=1: RUN lasts a single edge; Ovf = Cin_effective ^ Cout.
- Counter width is $clog2(WIDTH+1); cnt never exceeds WIDTH-1.
- Arithmetic results are all mod 2^WIDTH:
  - add: {Cout,Sum} = A+B+Cin.
  - subtract: Sum = A-B, Cout = (A>=B unsigned).

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - op encoding constants (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module: the existing one-bit dataflow full adder (ports A, B, Cin, Sum, Carry), instantiated once as the datapath.
- The FSM, counter and shift registers live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, add A=0x5A B=0x33 Cin=0 -> done 9 cycles after the start edge; Sum=0x8D, Cout=0, Ovf=1.
- Add A=0xFF B=0x01 Cin=1 -> Sum=0x01, Cout=1, Ovf=0; busy high exactly 8 cycles; done high exactly 1 cycle.
- sub=1:
  - A=0x10 B=0x20 -> Sum=0xF0, Cout=0, Ovf=0.
  - A=0x80 B=0x01 -> Sum=0x7F, Cout=1, Ovf=1.
- start pulsed with A=0x01 B=0x01, then start re-pulsed mid-RUN with A=0xAA B=0x55 -> single done; Sum=0x02; second request ignored.
- rst_n low for 1 cycle at cycle 4 of RUN -> outputs all 0 immediately (async), no done pulse; a fresh start afterward computes correctly.
- Back-to-back ops with start held high continuously -> new operation accepted only in IDLE (one op per WIDTH+2 cycles); Sum holds the previous result until the next done.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: shared state and op encodings for the bit-serial adder
package serial_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: host request/result bundle for the bit-serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start;
  logic sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Cin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] Sum;
  logic Cout;
  logic Ovf;
  modport master (output start, sub, A, B, Cin, input busy, done, Sum, Cout, Ovf);
  modport slave (input start, sub, A, B, Cin, output busy, done, Sum, Cout, Ovf);
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// serial_adder_ctrl_fa: one-bit dataflow full adder
module serial_adder_ctrl_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);
  assign Sum = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first add/subtract sequencer around one shared full adder
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, fa_s, fa_c, last;
  serial_adder_ctrl_fa fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .Sum(fa_s), .Carry(fa_c));
  assign last = state == RUN && cnt == CW'(WIDTH - 1);
  assign sum_nx = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  always_comb begin
    nxt = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      sum_sh <= '0;
      carry <= 1'b0;
      cnt <= '0;
      bus.Sum <= '0;
      bus.Cout <= 1'b0;
      bus.Ovf <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sh <= bus.A;
      b_sh <= bus.sub == OP_SUB ? ~bus.B : bus.B;
      carry <= bus.sub == OP_SUB ? 1'b1 : bus.Cin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      sum_sh <= sum_nx;
      carry <= fa_c;
      cnt <= last ? '0 : cnt + 1'b1;
      // carry still holds the carry into the MSB on the last bit
      if (last) begin
        bus.Sum <= sum_nx;
        bus.Cout <= fa_c;
        bus.Ovf <= carry ^ fa_c;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for the bit-serial adder
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nchk = 0;
  int nfail = 0;
  serial_adder_ctrl_if #(.WIDTH(8)) sif ();
  serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(sif));
  always #5 clk = ~clk;

  // lat counts negedges from the start edge until done is seen; bcnt counts busy cycles
  task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int bcnt);
    @(negedge clk);
    sif.sub = s; sif.A = a; sif.B = b; sif.Cin = c; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (sif.done !== 1'b1 && lat < 30) begin
      bcnt += int'(sif.busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    sif.start = 1'b0; sif.sub = 1'b0; sif.A = '0; sif.B = '0; sif.Cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nchk++; if ({sif.busy, sif.done, sif.Sum, sif.Cout, sif.Ovf} !== 12'h000) begin nfail++; $display("FAIL reset: busy/done/Sum/Cout/Ovf=%b expected all 0", {sif.busy, sif.done, sif.Sum, sif.Cout, sif.Ovf}); end
  endtask

  task automatic test_add();
    int lat, bcnt;
    run_op(1'b0, 8'h5A, 8'h33, 1'b0, lat, bcnt);
    nchk++; if (lat != 9) begin nfail++; $display("FAIL add1 latency: got %0d expected 9", lat); end
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'h8D, 1'b0, 1'b1}) begin nfail++; $display("FAIL add1 result: Sum=%h Cout=%b Ovf=%b expected 8d 0 1", sif.Sum, sif.Cout, sif.Ovf); end
    run_op(1'b0, 8'hFF, 8'h01, 1'b1, lat, bcnt);
    nchk++; if (bcnt != 8) begin nfail++; $display("FAIL add2 busy cycles: got %0d expected 8", bcnt); end
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'h01, 1'b1, 1'b0}) begin nfail++; $display("FAIL add2 result: Sum=%h Cout=%b Ovf=%b expected 01 1 0", sif.Sum, sif.Cout, sif.Ovf); end
    @(negedge clk);
    nchk++; if (sif.done !== 1'b0) begin nfail++; $display("FAIL add2 done width: done=%b expected 0 one cycle later", sif.done); end
  endtask

  task automatic test_sub();
    int lat, bcnt;
    run_op(1'b1, 8'h10, 8'h20, 1'b1, lat, bcnt);
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'hF0, 1'b0, 1'b0}) begin nfail++; $display("FAIL sub1 result: Sum=%h Cout=%b Ovf=%b expected f0 0 0", sif.Sum, sif.Cout, sif.Ovf); end
    run_op(1'b1, 8'h80, 8'h01, 1'b0, lat, bcnt);
    nchk++; if (lat != 9) begin nfail++; $display("FAIL sub2 latency: got %0d expected 9", lat); end
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'h7F, 1'b1, 1'b1}) begin nfail++; $display("FAIL sub2 result: Sum=%h Cout=%b Ovf=%b expected 7f 1 1", sif.Sum, sif.Cout, sif.Ovf); end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    @(negedge clk);
    sif.sub = 1'b0; sif.A = 8'h01; sif.B = 8'h01; sif.Cin = 1'b0; sif.start = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      sif.A = 8'hAA; sif.B = 8'h55; sif.sub = 1'b1; sif.Cin = 1'b1;
      sif.start = i <= 4;
      ndone += int'(sif.done);
    end
    nchk++; if (ndone != 1) begin nfail++; $display("FAIL ignore done count: got %0d expected 1", ndone); end
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'h02, 1'b0, 1'b0}) begin nfail++; $display("FAIL ignore result: Sum=%h Cout=%b Ovf=%b expected 02 0 0", sif.Sum, sif.Cout, sif.Ovf); end
  endtask

  task automatic test_abort();
    int lat, bcnt, ndone = 0;
    @(negedge clk);
    sif.sub = 1'b0; sif.A = 8'h5A; sif.B = 8'h33; sif.Cin = 1'b0; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nchk++; if ({sif.busy, sif.done, sif.Sum, sif.Cout, sif.Ovf} !== 12'h000) begin nfail++; $display("FAIL abort outputs: busy/done/Sum/Cout/Ovf=%b expected all 0", {sif.busy, sif.done, sif.Sum, sif.Cout, sif.Ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin @(negedge clk); ndone += int'(sif.done); end
    nchk++; if (ndone != 0) begin nfail++; $display("FAIL abort done count: got %0d expected 0", ndone); end
    run_op(1'b0, 8'h12, 8'h34, 1'b0, lat, bcnt);
    nchk++; if (lat != 9) begin nfail++; $display("FAIL abort fresh latency: got %0d expected 9", lat); end
    nchk++; if ({sif.Sum, sif.Cout, sif.Ovf} !== {8'h46, 1'b0, 1'b0}) begin nfail++; $display("FAIL abort fresh result: Sum=%h Cout=%b Ovf=%b expected 46 0 0", sif.Sum, sif.Cout, sif.Ovf); end
  endtask

  // start held high: accepts at the start edge and again WIDTH+2 edges later
  task automatic test_back_to_back();
    logic [7:0] exp_sum;
    @(negedge clk);
    sif.sub = 1'b0; sif.A = 8'h0F; sif.B = 8'h01; sif.Cin = 1'b0; sif.start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin sif.A = 8'h20; sif.B = 8'h03; end
      exp_sum = i < 9 ? 8'h46 : i < 19 ? 8'h10 : 8'h23;
      nchk++; if (sif.done !== (i == 9 || i == 19)) begin nfail++; $display("FAIL b2b done@%0d: got %b expected %b", i, sif.done, i == 9 || i == 19); end
      nchk++; if (sif.Sum !== exp_sum) begin nfail++; $display("FAIL b2b Sum@%0d: got %h expected %h", i, sif.Sum, exp_sum); end
      if (i == 20) sif.start = 1'b0;
    end
    repeat (3) @(negedge clk);
    nchk++; if (sif.busy !== 1'b0) begin nfail++; $display("FAIL b2b idle: busy=%b expected 0", sif.busy); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
